// File: rtl/lockreg_bank.sv
// lockreg_bank: bank of NUM_REGS lockable data registers with sticky lock bits,
// violation pulse/address reporting and a saturating violation counter.
// Optional two-step key unlock FSM compiled in with LOCKREG_BANK_UNLOCK_EN.
module lockreg_bank #(
   parameter int               WIDTH     = 16,
   parameter int               NUM_REGS  = 4,
   parameter int               ADDR_W    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               VCNT_W    = 8,
   parameter logic [WIDTH-1:0] KEY1      = 16'hA5C3,
   parameter logic [WIDTH-1:0] KEY2      = 16'h3C5A
) (
   input  logic                Clk,
   input  logic                resetn,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   input  logic                trusted,
   input  logic [NUM_REGS-1:0] lock_set,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [WIDTH-1:0]    rd_data,
   output logic [NUM_REGS-1:0] lock_status,
   output logic                violation,
   output logic [ADDR_W-1:0]   viol_addr,
   output logic [VCNT_W-1:0]   viol_count,
   input  logic                unlock_req,
   input  logic [ADDR_W-1:0]   unlock_addr,
   input  logic [WIDTH-1:0]    unlock_key
);

   logic [WIDTH-1:0]    regs_q [NUM_REGS];
   logic [WIDTH-1:0]    regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] lock_q, lock_d;
   logic [WIDTH-1:0]    rd_data_q, rd_data_d;
   logic                violation_q, violation_d;
   logic [ADDR_W-1:0]   viol_addr_q, viol_addr_d;
   logic [VCNT_W-1:0]   viol_count_q, viol_count_d;

   // Results of the unlock path, consumed by the main datapath.
   logic [NUM_REGS-1:0] unlock_clr;
   logic                unlock_viol;
   logic [ADDR_W-1:0]   unlock_viol_addr;

`ifdef LOCKREG_BANK_UNLOCK_EN
   typedef enum logic {IDLE, ARMED} unlock_state_e;

   unlock_state_e     state_q, state_d;
   logic [ADDR_W-1:0] arm_addr_q, arm_addr_d;

   // Unlock handshake: KEY1 arms and captures the address, KEY2 on the very next cycle clears the lock.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d          = state_q;
      arm_addr_d       = arm_addr_q;
      unlock_clr       = '0;
      unlock_viol      = 1'b0;
      unlock_viol_addr = unlock_addr;
      case (state_q)
         IDLE: begin
            if (unlock_req) begin
               if (trusted && unlock_key == KEY1) begin
                  state_d    = ARMED;
                  arm_addr_d = unlock_addr;
               end else begin
                  unlock_viol = 1'b1;
               end
            end
         end
         ARMED: begin
            state_d = IDLE;
            if (unlock_req && trusted && unlock_key == KEY2 && unlock_addr == arm_addr_q) begin
               unlock_clr[arm_addr_q] = 1'b1;
            end else begin
               unlock_viol      = 1'b1;
               unlock_viol_addr = arm_addr_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Unlock FSM state; reset aborts any handshake in progress.
   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         arm_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         arm_addr_q <= arm_addr_d;
      end
   end
`else
   // Unlock ports are present but have no effect in this build.
   logic unused_unlock;
   assign unused_unlock    = ^{unlock_req, unlock_addr, unlock_key, KEY1, KEY2};
   assign unlock_clr       = '0;
   assign unlock_viol      = 1'b0;
   assign unlock_viol_addr = '0;
`endif

   logic              wr_blocked;
   logic [1:0]        viol_inc;
   logic [VCNT_W:0]   cnt_sum;

   // Next-state for data, locks, read port and violation reporting.
   always_comb begin
      regs_d       = regs_q;
      rd_data_d    = regs_q[rd_addr];
      // A lock requested in this same cycle already protects the target.
      wr_blocked   = wr_en && !trusted && (lock_q[wr_addr] || lock_set[wr_addr]);
      if (wr_en && !wr_blocked) begin
         regs_d[wr_addr] = wr_data;
      end

      // lock_set is ORed in after the clear so a same-cycle relock wins.
      lock_d       = (lock_q & ~unlock_clr) | lock_set;

      violation_d  = wr_blocked || unlock_viol;
      viol_addr_d  = viol_addr_q;
      if (wr_blocked) begin
         viol_addr_d = wr_addr;
      end else if (unlock_viol) begin
         viol_addr_d = unlock_viol_addr;
      end

      // A write and an unlock attempt may both be blocked in one cycle; each counts.
      viol_inc     = {1'b0, wr_blocked} + {1'b0, unlock_viol};
      cnt_sum      = {1'b0, viol_count_q} + {{(VCNT_W-1){1'b0}}, viol_inc};
      viol_count_d = cnt_sum[VCNT_W] ? {VCNT_W{1'b1}} : cnt_sum[VCNT_W-1:0];
   end

   // All architectural state, cleared asynchronously.
   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: the data array is reset explicitly because its reset value is visible architecturally.
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
         lock_q       <= '0;
         rd_data_q    <= '0;
         violation_q  <= 1'b0;
         viol_addr_q  <= '0;
         viol_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         regs_q       <= regs_d;
         lock_q       <= lock_d;
         rd_data_q    <= rd_data_d;
         violation_q  <= violation_d;
         viol_addr_q  <= viol_addr_d;
         viol_count_q <= viol_count_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign lock_status = lock_q;
   assign violation   = violation_q;
   assign viol_addr   = viol_addr_q;
   assign viol_count  = viol_count_q;

endmodule

// File: tb/tb_lockreg_bank.sv
// Directed testbench for lockreg_bank (default parameters).
// Expectations for the unlock tests follow LOCKREG_BANK_UNLOCK_EN.
module tb_lockreg_bank;

   localparam logic [15:0] KEY1 = 16'hA5C3;
   localparam logic [15:0] KEY2 = 16'h3C5A;
`ifdef LOCKREG_BANK_UNLOCK_EN
   localparam bit UNLOCK = 1'b1;
`else
   localparam bit UNLOCK = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        resetn;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [15:0] wr_data;
   logic        trusted;
   logic [3:0]  lock_set;
   logic [1:0]  rd_addr;
   logic [15:0] rd_data;
   logic [3:0]  lock_status;
   logic        violation;
   logic [1:0]  viol_addr;
   logic [7:0]  viol_count;
   logic        unlock_req;
   logic [1:0]  unlock_addr;
   logic [15:0] unlock_key;

   int checks = 0;
   int errors = 0;

   lockreg_bank dut (
      .Clk(Clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .trusted(trusted), .lock_set(lock_set), .rd_addr(rd_addr), .rd_data(rd_data),
      .lock_status(lock_status), .violation(violation), .viol_addr(viol_addr),
      .viol_count(viol_count), .unlock_req(unlock_req), .unlock_addr(unlock_addr),
      .unlock_key(unlock_key)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (rd_data !== 16'h0 || lock_status !== 4'h0 || violation !== 1'b0 ||
          viol_addr !== 2'd0 || viol_count !== 8'd0) begin
         errors++;
         $display("FAIL %s: rd=%h lock=%b viol=%b vaddr=%0d vcnt=%0d expected all zero",
                  tag, rd_data, lock_status, violation, viol_addr, viol_count);
      end
   endtask

   task automatic idle_inputs();
      wr_en = 0; wr_addr = 0; wr_data = 0; trusted = 0; lock_set = 0;
      unlock_req = 0; unlock_addr = 0; unlock_key = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 1'b0;
      #12;
      resetn = 1'b1;
      #3;
   endtask

   task automatic test_reset();
      idle_inputs();
      rd_addr = 0;
      resetn  = 1'b0;
      #7;
      check_reset_outputs("reset_state");
      resetn = 1'b1;
      #3;
      tick();
      check_reset_outputs("post_reset_idle");
   endtask

   task automatic test_unlocked_write();
      wr_en = 1; wr_addr = 1; wr_data = 16'h1234; trusted = 0; rd_addr = 1;
      tick();
      wr_en = 0;
      chk("same_cycle_read_old", rd_data, 16'h0000);
      chk("unlocked_no_viol", {15'b0, violation}, 16'h0);
      tick();
      chk("unlocked_write_data", rd_data, 16'h1234);
      chk("unlocked_vcnt", {8'b0, viol_count}, 16'd0);
   endtask

   task automatic test_lock_write();
      lock_set = 4'b0010;
      tick();
      lock_set = 4'b0000;
      chk("lock_set_status", {12'b0, lock_status}, 16'h0002);
      wr_en = 1; wr_addr = 1; wr_data = 16'hBEEF; trusted = 0;
      tick();
      wr_en = 0;
      chk("blocked_viol_pulse", {15'b0, violation}, 16'h1);
      chk("blocked_viol_addr", {14'b0, viol_addr}, 16'd1);
      chk("blocked_vcnt", {8'b0, viol_count}, 16'd1);
      tick();
      chk("blocked_viol_drops", {15'b0, violation}, 16'h0);
      chk("blocked_data_kept", rd_data, 16'h1234);
      wr_en = 1; trusted = 1;
      tick();
      wr_en = 0; trusted = 0;
      chk("trusted_no_viol", {15'b0, violation}, 16'h0);
      tick();
      chk("trusted_write_data", rd_data, 16'hBEEF);
      chk("trusted_vcnt_same", {8'b0, viol_count}, 16'd1);
      chk("lock_sticky", {12'b0, lock_status}, 16'h0002);
   endtask

   task automatic test_lock_priority();
      lock_set = 4'b0100; wr_en = 1; wr_addr = 2; wr_data = 16'h00FF; trusted = 0; rd_addr = 2;
      tick();
      lock_set = 0; wr_en = 0;
      chk("prio_lock_status", {12'b0, lock_status}, 16'h0006);
      chk("prio_viol", {15'b0, violation}, 16'h1);
      chk("prio_viol_addr", {14'b0, viol_addr}, 16'd2);
      chk("prio_vcnt", {8'b0, viol_count}, 16'd2);
      tick();
      chk("prio_data_reset_val", rd_data, 16'h0000);
   endtask

   task automatic test_back_to_back();
      wr_en = 1; wr_addr = 1; wr_data = 16'h5555; trusted = 0; rd_addr = 1;
      tick();
      chk("b2b_pulse1", {15'b0, violation}, 16'h1);
      chk("b2b_cnt1", {8'b0, viol_count}, 16'd3);
      tick();
      chk("b2b_pulse2", {15'b0, violation}, 16'h1);
      chk("b2b_cnt2", {8'b0, viol_count}, 16'd4);
      for (int i = 0; i < 300; i++) tick();
      chk("sat_cnt", {8'b0, viol_count}, 16'd255);
      chk("sat_viol_high", {15'b0, violation}, 16'h1);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_cnt_holds", {8'b0, viol_count}, 16'd255);
      wr_en = 0;
      tick();
      chk("sat_viol_drops", {15'b0, violation}, 16'h0);
      chk("sat_data_kept", rd_data, 16'hBEEF);
   endtask

   task automatic test_unlock();
      do_reset();
      lock_set = 4'b0010;
      tick();
      lock_set = 0;
      unlock_req = 1; trusted = 1; unlock_addr = 1; unlock_key = KEY1;
      tick();
      chk("unlock_arm_no_viol", {15'b0, violation}, 16'h0);
      unlock_key = KEY2;
      tick();
      unlock_req = 0; trusted = 0;
      chk("unlock_lock_status", {12'b0, lock_status}, UNLOCK ? 16'h0000 : 16'h0002);
      chk("unlock_no_viol", {15'b0, violation}, 16'h0);
      chk("unlock_vcnt", {8'b0, viol_count}, 16'd0);
      tick();
      lock_set = 4'b0010;
      tick();
      lock_set = 0;
      unlock_req = 1; trusted = 1; unlock_addr = 1; unlock_key = KEY1;
      tick();
      unlock_key = 16'h0000;
      tick();
      unlock_req = 0; trusted = 0;
      chk("badkey_lock_status", {12'b0, lock_status}, 16'h0002);
      chk("badkey_viol", {15'b0, violation}, UNLOCK ? 16'h1 : 16'h0);
      chk("badkey_viol_addr", {14'b0, viol_addr}, UNLOCK ? 16'd1 : 16'd0);
      chk("badkey_vcnt", {8'b0, viol_count}, UNLOCK ? 16'd1 : 16'd0);
      tick();
      chk("badkey_viol_drops", {15'b0, violation}, 16'h0);
   endtask

   task automatic test_reset_armed();
      do_reset();
      unlock_req = 1; trusted = 1; unlock_addr = 1; unlock_key = KEY1;
      tick();
      idle_inputs();
      #2;
      resetn = 1'b0;
      #1;
      check_reset_outputs("reset_armed_outputs");
      #5;
      resetn = 1'b1;
      #1;
      lock_set = 4'b0010;
      tick();
      lock_set = 0;
      unlock_req = 1; trusted = 1; unlock_addr = 1; unlock_key = KEY2;
      tick();
      unlock_req = 0; trusted = 0;
      chk("lone_key2_locked", {12'b0, lock_status}, 16'h0002);
      chk("lone_key2_viol", {15'b0, violation}, UNLOCK ? 16'h1 : 16'h0);
      chk("lone_key2_vcnt", {8'b0, viol_count}, UNLOCK ? 16'd1 : 16'd0);
   endtask

   initial begin
      test_reset();
      test_unlocked_write();
      test_lock_write();
      test_lock_priority();
      test_back_to_back();
      test_unlock();
      test_reset_armed();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
